// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable frame format, glitch/break detection and a show-ahead
// receive FIFO drained through a valid/ready handshake.
module uart_rx_fifo #(
  parameter int unsigned CLK_FREQ   = 25_000_000,
  parameter int unsigned BAUDRATE   = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  output logic [DATA_BITS-1:0]          rx_data_o,
  output logic                          rx_perr_o,
  output logic                          rx_ferr_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  output logic                          break_o,
  input  logic                          clr_i
);

  localparam int unsigned BitCycles = CLK_FREQ / BAUDRATE;
  localparam int unsigned Half      = BitCycles / 2;
  localparam int unsigned CntW      = $clog2(BitCycles + 1);
  localparam int unsigned IdxW      = $clog2(DATA_BITS);
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW      = DATA_BITS + 2;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  logic                 rx_meta, rx_s;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic                 ferr_now, sample_bit, push, brk;
  logic [EntW-1:0]      push_entry;

  // Synchroniser resets to idle level so reset release cannot look like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  assign sample_bit = (cnt_q == CntW'(BitCycles - 1));
  assign push_entry = {perr_q, ferr_now, data_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    data_d   = data_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    ferr_now = ferr_q | ~rx_s;
    push     = 1'b0;
    brk      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CntW'(Half - 1)) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            idx_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      StData: begin
        if (sample_bit) begin
          cnt_d  = '0;
          data_d = {rx_s, data_q[DATA_BITS-1:1]};
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? StParity : StStop;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (sample_bit) begin
          perr_d  = (PARITY == 2) ? (^data_q ^ rx_s) : ~(^data_q ^ rx_s);
          state_d = StStop;
        end
      end
      StStop: begin
        if (sample_bit) begin
          cnt_d = '0;
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            if (data_q == '0 && ferr_now && !rx_s) begin
              brk     = 1'b1;
              state_d = StBreak;
            end else begin
              push    = 1'b1;
              state_d = StIdle;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            ferr_d = ferr_now;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Receive FIFO
  logic [EntW-1:0] mem [FIFO_DEPTH];
  logic [PtrW:0]   wptr_q, rptr_q;
  logic [EntW-1:0] last_q, head;
  logic            full, empty, pop, do_push, overrun_q, break_q;

  assign level_o = wptr_q - rptr_q;
  assign empty   = (level_o == '0);
  assign full    = (level_o == (PtrW + 1)'(FIFO_DEPTH));
  assign pop     = !empty && rx_ready_i;
  assign do_push = push && (!full || pop);
  // When empty, present the last entry handed out rather than stale storage.
  assign head    = empty ? last_q : mem[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr_q[PtrW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      last_q    <= '0;
      overrun_q <= 1'b0;
      break_q   <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        last_q <= head;
      end
      if (push && full && !pop) overrun_q <= 1'b1;
      else if (clr_i)           overrun_q <= 1'b0;
      break_q <= brk;
    end
  end

  assign rx_data_o  = head[DATA_BITS-1:0];
  assign rx_ferr_o  = head[DATA_BITS];
  assign rx_perr_o  = head[DATA_BITS+1];
  assign rx_valid_o = !empty;
  assign overrun_o  = overrun_q;
  assign break_o    = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: a default 8N1 receiver and a fast 8E2 receiver, each checked against a
// frame-level reference model.
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx0, ready0, clr0, valid0, perr0, ferr0, ovr0, brk0;
  logic [7:0] data0;
  logic [4:0] level0;
  logic       rx1, ready1, clr1, valid1, perr1, ferr1, ovr1, brk1;
  logic [7:0] data1;
  logic [4:0] level1;

  uart_rx_fifo dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx0), .rx_data_o(data0), .rx_perr_o(perr0),
    .rx_ferr_o(ferr0), .rx_valid_o(valid0), .rx_ready_i(ready0), .level_o(level0),
    .overrun_o(ovr0), .break_o(brk0), .clr_i(clr0)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUDRATE(100_000), .PARITY(2), .STOP_BITS(2)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx1), .rx_data_o(data1), .rx_perr_o(perr1),
    .rx_ferr_o(ferr1), .rx_valid_o(valid1), .rx_ready_i(ready1), .level_o(level1),
    .overrun_o(ovr1), .break_o(brk1), .clr_i(clr1)
  );

  int n_checks = 0;
  int n_fail = 0;
  int brk_cnt0 = 0;
  int brk_cnt1 = 0;
  logic rand_ready = 1'b0;
  logic [9:0] q0[$];
  logic [9:0] q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: entry is {perr, ferr, data}; even parity counts data plus parity bit.
  function automatic logic [9:0] model(input logic [7:0] d, input logic p, input logic s1,
                                       input logic s2);
    logic perr, ferr;
    perr = (^d) ^ p;
    ferr = !(s1 && s2);
    return {perr, ferr, d};
  endfunction

  // Monitor: every accepted handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (brk0) brk_cnt0++;
      if (brk1) brk_cnt1++;
      if (valid0 && ready0) begin
        if (q0.size() == 0) check("dut0_unexpected_entry", {22'd0, perr0, ferr0, data0}, 32'hFFFF);
        else check("dut0_entry", {22'd0, perr0, ferr0, data0}, {22'd0, q0.pop_front()});
      end
      if (valid1 && ready1) begin
        if (q1.size() == 0) check("dut1_unexpected_entry", {22'd0, perr1, ferr1, data1}, 32'hFFFF);
        else check("dut1_entry", {22'd0, perr1, ferr1, data1}, {22'd0, q1.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) ready1 = 1'($urandom_range(0, 1));
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic [15:0] bits, input int n);
    int bc;
    bc = (which == 0) ? 217 : 16;
    for (int i = 0; i < n; i++) begin
      if (which == 0) rx0 = bits[i];
      else rx1 = bits[i];
      cycles(bc);
    end
  endtask

  task automatic send_main(input logic [7:0] d, input logic stop);
    drive(0, {6'd0, stop, d, 1'b0}, 10);
  endtask

  task automatic send_fast(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    drive(1, {4'd0, s2, s1, p, d, 1'b0}, 12);
  endtask

  task automatic drain1(input string name);
    int n;
    n = 0;
    ready1 = 1'b1;
    while ((q1.size() != 0 || valid1) && n < 1000) begin
      cycles(1);
      n++;
    end
    ready1 = 1'b0;
    cycles(2);
    check(name, q1.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    logic p, s1, s2;
    int exp_brk;
    rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b0; ready1 = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    cycles(3);
    @(negedge clk);
    check("reset_valid", valid0, 0);
    check("reset_level", level0, 0);
    check("reset_data", data0, 0);
    check("reset_ovr_brk", {ovr0, brk0, ovr1, brk1}, 0);
    cycles(1);
    rst_n = 1'b1;
    cycles(5);

    // 8N1 byte held in the FIFO, then popped with a single-cycle ready
    q0.push_back(10'h068);
    send_main(8'h68, 1'b1);
    cycles(10);
    @(negedge clk);
    check("t1_valid", valid0, 1);
    check("t1_data", data0, 32'h68);
    check("t1_errs", {perr0, ferr0}, 0);
    check("t1_level", level0, 1);
    cycles(1);
    ready0 = 1'b1;
    cycles(1);
    ready0 = 1'b0;
    @(negedge clk);
    check("t1_level_after_pop", level0, 0);
    check("t1_valid_after_pop", valid0, 0);
    cycles(1);

    // Short low pulse is a glitch
    rx0 = 1'b0;
    cycles(50);
    rx0 = 1'b1;
    cycles(3000);
    check("t2_level", level0, 0);
    check("t2_valid", valid0, 0);

    // Even parity: good and bad parity bit
    q1.push_back(model(8'h68, 1'b1, 1'b1, 1'b1));
    send_fast(8'h68, 1'b1, 1'b1, 1'b1);
    q1.push_back(model(8'h68, 1'b0, 1'b1, 1'b1));
    send_fast(8'h68, 1'b0, 1'b1, 1'b1);
    cycles(20);
    check("t3_level", level1, 2);
    drain1("t3_drain");

    // Framing error, then a break, then a clean frame
    ready0 = 1'b1;
    exp_brk = brk_cnt0;
    q0.push_back(10'h155);
    send_main(8'h55, 1'b0);
    rx0 = 1'b1;
    cycles(500);
    check("t4_no_break_on_ferr", brk_cnt0, exp_brk);
    check("t4_ferr_popped", q0.size(), 0);
    rx0 = 1'b0;
    cycles(20 * 217);
    rx0 = 1'b1;
    cycles(500);
    check("t4_one_break", brk_cnt0, exp_brk + 1);
    check("t4_no_break_entry", level0, 0);
    q0.push_back(10'h041);
    send_main(8'h41, 1'b1);
    cycles(300);
    check("t4_after_break", q0.size(), 0);
    ready0 = 1'b0;

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      d = 8'(i);
      p = ^d;
      if (i < 16) q1.push_back(model(d, p, 1'b1, 1'b1));
      send_fast(d, p, 1'b1, 1'b1);
    end
    cycles(20);
    check("t5_level_full", level1, 16);
    check("t5_overrun", ovr1, 1);
    drain1("t5_drain");
    check("t5_overrun_sticky", ovr1, 1);
    clr1 = 1'b1;
    cycles(1);
    clr1 = 1'b0;
    @(negedge clk);
    check("t5_overrun_cleared", ovr1, 0);
    cycles(1);

    // Reset in the middle of data bit 4 of 0xA5
    drive(0, 16'h014A, 5);
    rx0 = 1'b0;
    cycles(100);
    rst_n = 1'b0;
    rx0 = 1'b1;
    @(negedge clk);
    check("t6_reset_outputs", {valid0, perr0, ferr0, data0, level0, ovr0, brk0}, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(500);
    check("t6_nothing_pushed", level0, 0);
    q0.push_back(10'h03C);
    send_main(8'h3C, 1'b1);
    cycles(10);
    @(negedge clk);
    check("t6_level", level0, 1);
    check("t6_head", {perr0, ferr0, data0}, 32'h03C);
    cycles(1);
    ready0 = 1'b1;
    cycles(3);
    ready0 = 1'b0;
    check("t6_popped", q0.size(), 0);

    // Randomised frames with random consumer back-pressure
    exp_brk = brk_cnt1;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      p = (^d) ^ ($urandom_range(0, 4) == 0);
      s1 = ($urandom_range(0, 4) != 0);
      s2 = ($urandom_range(0, 4) != 0);
      if (d == 8'h00 && !s2) exp_brk++;
      else q1.push_back(model(d, p, s1, s2));
      send_fast(d, p, s1, s2);
      rx1 = 1'b1;
      cycles($urandom_range(4, 24));
    end
    cycles(40);
    rand_ready = 1'b0;
    cycles(1);
    drain1("rand_drain");
    check("rand_breaks", brk_cnt1, exp_brk);
    check("rand_no_overrun", ovr1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised, synthesizable UART receiver with a show-ahead receive FIFO, for use in the cv32e40x SoC peripheral set. It generalises the fixed 8N1 serial path: data width, parity mode, stop-bit count and FIFO depth are configurable. It also adds glitch rejection, per-byte error flags, overrun detection and break detection. Downstream logic drains it with a valid/ready handshake.

Parameters:
CLK_FREQ, 25_000_000, core clock in Hz
BAUDRATE, 115200, bit rate; BIT_CYCLES = CLK_FREQ/BAUDRATE (integer), HALF = BIT_CYCLES/2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 none / 1 odd / 2 even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, entries, power of two, >=2

Ports:
clk_i  in  1  core clock
rst_ni  in  1  asynchronous active-low reset
rx_i  in  1  serial input, asynchronous, idle high
rx_data_o  out  DATA_BITS  head-of-FIFO data
rx_perr_o  out  1  head entry parity error
rx_ferr_o  out  1  head entry framing error
rx_valid_o  out  1  FIFO non-empty
rx_ready_i  in  1  consumer accepts head entry
level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
overrun_o  out  1  sticky: frame dropped because FIFO full
break_o  out  1  one-cycle pulse on break detection
clr_i  in  1  clears overrun_o

Behaviour:
- Reset values: all outputs 0; FSM IDLE; FIFO empty; both synchroniser flops 1, so reset cannot create a false start.
- rx_i passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s.
- Bit counter: one counter, cleared on every state entry. A sample is taken when the counter reaches its terminal value.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: rx_s==0 -> START.
- START: sample at count HALF-1.
  - rx_s==1 is a glitch: -> IDLE, nothing pushed.
  - Otherwise -> DATA, bit index 0.
- DATA: sample every BIT_CYCLES cycles. Shift in LSB first, rx_data[idx] = rx_s.
  - After DATA_BITS samples: -> PARITY if PARITY!=0, else STOP.
- PARITY: sample after BIT_CYCLES.
  - Even mode: perr = XOR(data, bit).
  - Odd mode: perr = ~XOR(data, bit).
- STOP: sample after BIT_CYCLES per stop bit. ferr = 1 if any stop sample is 0.
  - STOP_BITS=2: if the first stop sample is 0, the FSM still samples the second stop bit.
- Frame end, at the sample cycle of the last stop bit (mid-bit):
  - Break: data==0 and ferr==1 and rx_s==0. Pulse break_o for 1 cycle, push nothing, -> BREAK.
  - Otherwise push {perr, ferr, data} and -> IDLE. The next start bit can be detected from the following cycle.
- BREAK: stay until rx_s==1, then -> IDLE. No start is detected while in BREAK.
- FIFO, show-ahead:
  - A push becomes visible on rx_data_o/rx_valid_o 1 cycle later. There is no same-cycle bypass.
  - Pop occurs when rx_valid_o && rx_ready_i. The next entry appears in the following cycle.
  - Pointers wrap modulo FIFO_DEPTH. level_o is in 0..FIFO_DEPTH.
  - Push when full with no pop: entry discarded, FIFO contents unchanged, overrun_o set.
  - Push and pop in the same cycle when full: both occur, level unchanged, no overrun.
  - Push and pop in the same cycle when empty: push occurs, pop ignored (rx_valid_o was 0).
  - rx_ready_i is ignored when rx_valid_o==0.
- overrun_o is sticky. clr_i clears it in the next cycle. If a set and clr_i coincide, set wins.
- When empty, rx_data_o/perr/ferr hold the last-read storage value. Only rx_valid_o qualifies them.
- Reset mid-frame: the frame is abandoned, the FIFO is emptied and overrun_o is cleared. The partially shifted byte is never pushed.
- Latency: rx_valid_o rises 2 sync cycles + 1 cycle after the mid-point of the last stop bit.

Test Plan:
1. Defaults (217 cycles/bit). Send 0x68 'h' 8N1, rx_ready_i=0 -> rx_valid_o=1, rx_data_o=0x68, perr=0, ferr=0, level_o=1. Then assert rx_ready_i for 1 cycle -> level_o=0, rx_valid_o=0.
2. Drive rx_i low for 50 cycles, then high for 3000 cycles -> no push, level_o=0, FSM back in IDLE.
3. PARITY=2: send 0x68 with parity bit 1 -> perr=0. Send 0x68 with parity bit 0 -> perr=1, data 0x68 still delivered.
4. Send 0x55 with stop bit 0, then idle -> entry 0x55 with ferr=1, break_o stays 0. Then hold rx_i low for 20 bit times -> exactly one break_o pulse and no entry; the next valid 0x41 frame is received correctly.
5. rx_ready_i=0: send 17 bytes 0x00..0x10 -> level_o=16, overrun_o=1. Drain 16 entries: 0x00..0x0F in order. Pulse clr_i -> overrun_o=0.
6. Assert rst_ni low for 2 cycles in the middle of data bit 4 of 0xA5 -> all outputs 0. The following full frame 0x3C is received as one entry with no error.
